// File: rtl/udp_rx_pingpong.sv
// rtl/udp_rx_pingpong.sv - UDP receive path with two ping-pong payload banks and a 2-entry commit queue
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   udp_rx_req                    datagram start pulse (IDLE only)
//   rx_valid, rx_data             header + payload byte stream, MSB byte first
//   upper_layer_data_length       UDP length L from the IP layer
//   net_protocol, ip_rec_*_addr   pseudo-header fields for the checksum
//   ip_error                      aborts the datagram in HEAD/DATA
//   mac_rec_error                 sampled in COMMIT; turns the commit into a drop
//   frame_valid/ch/len            oldest committed datagram
//   frame_ack                     pops the oldest datagram and frees its bank
//   rd_addr, rd_data              payload read port on the oldest bank (1-cycle latency)
//   drop_cnt                      saturating dropped-datagram count
module udp_rx_pingpong #(
  parameter int          ADDR_W    = 10,
  parameter int          NUM_CH    = 4,
  parameter logic [15:0] PORT_BASE = 16'd8080,
  parameter int          CH_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              udp_rx_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [15:0]       upper_layer_data_length,
  input  logic [7:0]        net_protocol,
  input  logic [31:0]       ip_rec_source_addr,
  input  logic [31:0]       ip_rec_destination_addr,
  input  logic              ip_error,
  input  logic              mac_rec_error,
  output logic              frame_valid,
  output logic [CH_W-1:0]   frame_ch,
  output logic [15:0]       frame_len,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [15:0]       drop_cnt
);
  typedef enum logic [2:0] {IDLE, HEAD, DATA, VERIFY, COMMIT, DROP} state_t;

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [16:0] BANK_BYTES = 17'(DEPTH);

  state_t state, state_nxt;

  logic [7:0]      bank0 [DEPTH];
  logic [7:0]      bank1 [DEPTH];

  logic [15:0]     len_q, cnt_q, dst_port_q, csum_fld_q;
  logic [7:0]      hold_q;
  logic [31:0]     sum_q;
  logic            wr_bank_q, abort_q, abort_nxt;
  logic [1:0]      bank_full_q;

  logic            q_bank_q [2];
  logic [CH_W-1:0] q_ch_q   [2];
  logic [15:0]     q_len_q  [2];
  logic            q_head_q;
  logic [1:0]      q_cnt_q;

  logic [15:0]     cnt_nxt, port_off;
  logic            byte_last, port_ok, len_ok, csum_ok;
  logic [16:0]     fold1;
  logic [15:0]     fold2;
  logic [31:0]     pseudo_sum;
  logic            pop, push, push_idx, drop_inc;
  logic [ADDR_W-1:0] wr_addr;

  assign cnt_nxt   = cnt_q + {15'd0, rx_valid};
  assign byte_last = (cnt_q == len_q - 16'd1);
  assign port_off  = dst_port_q - PORT_BASE;
  assign port_ok   = (dst_port_q >= PORT_BASE) && (port_off < 16'(NUM_CH));
  assign len_ok    = ({1'b0, len_q} - 17'd8) <= BANK_BYTES;
  // Two end-around folds bring any 32-bit accumulation down to 16 bits.
  assign fold1     = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2     = fold1[15:0] + {15'd0, fold1[16]};
  assign csum_ok   = (fold2 == 16'hFFFF) || (csum_fld_q == 16'h0000);
  assign pseudo_sum = {16'd0, ip_rec_source_addr[31:16]} + {16'd0, ip_rec_source_addr[15:0]}
                    + {16'd0, ip_rec_destination_addr[31:16]} + {16'd0, ip_rec_destination_addr[15:0]}
                    + {24'd0, net_protocol} + {16'd0, upper_layer_data_length};

  assign frame_valid = (q_cnt_q != 2'd0);
  assign frame_ch    = frame_valid ? q_ch_q[q_head_q] : '0;
  assign frame_len   = frame_valid ? q_len_q[q_head_q] : 16'd0;
  assign pop         = frame_ack && frame_valid;
  assign push        = (state == COMMIT) && !mac_rec_error;
  // A push only happens with at most one entry queued (a bank was free).
  assign push_idx    = q_head_q ^ q_cnt_q[0];
  assign wr_addr     = cnt_q[ADDR_W-1:0] - ADDR_W'(8);

  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    unique case (state)
      IDLE:   if (udp_rx_req) state_nxt = (&bank_full_q) ? DROP : HEAD;
      HEAD: begin
        if (ip_error) begin
          state_nxt = DROP;
          abort_nxt = 1'b1;
        end else if (len_q < 16'd8) begin
          // No room for a header; DROP still consumes the L bytes.
          state_nxt = DROP;
        end else if (rx_valid && cnt_q == 16'd7) begin
          if (!len_ok || !port_ok)  state_nxt = DROP;
          else if (len_q == 16'd8)  state_nxt = VERIFY;
          else                      state_nxt = DATA;
        end
      end
      DATA: begin
        if (ip_error) begin
          state_nxt = DROP;
          abort_nxt = 1'b1;
        end else if (rx_valid && byte_last) begin
          state_nxt = VERIFY;
        end
      end
      VERIFY: state_nxt = csum_ok ? COMMIT : DROP;
      COMMIT: state_nxt = IDLE;
      DROP:   if (abort_q || cnt_nxt >= len_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign drop_inc = ((state_nxt == DROP) && (state != DROP)) || ((state == COMMIT) && mac_rec_error);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      abort_q     <= 1'b0;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      dst_port_q  <= 16'd0;
      csum_fld_q  <= 16'd0;
      hold_q      <= 8'd0;
      sum_q       <= 32'd0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      q_head_q    <= 1'b0;
      q_cnt_q     <= 2'd0;
      drop_cnt    <= 16'd0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort_nxt;

      if (state == IDLE) begin
        cnt_q <= 16'd0;
        if (udp_rx_req) begin
          len_q     <= upper_layer_data_length;
          wr_bank_q <= bank_full_q[0];
          sum_q     <= pseudo_sum;
        end
      end else begin
        cnt_q <= cnt_nxt;
      end

      if ((state == HEAD || state == DATA) && rx_valid) begin
        hold_q <= rx_data;
        if (cnt_q[0])       sum_q <= sum_q + {16'd0, hold_q, rx_data};
        else if (byte_last) sum_q <= sum_q + {16'd0, rx_data, 8'h00};
        if (cnt_q == 16'd3) dst_port_q <= {hold_q, rx_data};
        if (cnt_q == 16'd7) csum_fld_q <= {hold_q, rx_data};
      end

      if (pop) begin
        bank_full_q[q_bank_q[q_head_q]] <= 1'b0;
        q_head_q <= ~q_head_q;
      end
      if (push) begin
        q_bank_q[push_idx]     <= wr_bank_q;
        q_ch_q[push_idx]       <= port_off[CH_W-1:0];
        q_len_q[push_idx]      <= len_q - 16'd8;
        bank_full_q[wr_bank_q] <= 1'b1;
      end
      q_cnt_q <= q_cnt_q + {1'b0, push} - {1'b0, pop};

      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && rx_valid && !ip_error) begin
      if (wr_bank_q) bank1[wr_addr] <= rx_data;
      else           bank0[wr_addr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    rd_data <= 8'd0;
    else if (q_bank_q[q_head_q]) rd_data <= bank1[rd_addr];
    else                        rd_data <= bank0[rd_addr];
  end
endmodule
